// File: rtl/ibex_instr_bus_arbiter_pkg.sv
// ibex_instr_bus_arbiter_pkg: shared types for the instruction-bus arbiter slice
package ibex_instr_bus_arbiter_pkg;
  typedef enum logic {INSTR_OWNER_IF = 1'b0, INSTR_OWNER_AUX = 1'b1} instr_owner_e;
endpackage

// File: rtl/ibex_instr_owner_fifo.sv
// ibex_instr_owner_fifo: in-order record of which requester owns each granted transaction
module ibex_instr_owner_fifo
  import ibex_instr_bus_arbiter_pkg::*;
#(
  parameter int Depth = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push,
  input  instr_owner_e                 owner,
  input  logic                         pop,
  output instr_owner_e                 head,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(Depth+1)-1:0]   count
);
  localparam int CntW = $clog2(Depth + 1);
  localparam int PtrW = Depth > 1 ? $clog2(Depth) : 1;
  logic [Depth-1:0] mem_q;
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  cnt_q;
  function automatic logic [PtrW-1:0] nxt(input logic [PtrW-1:0] p);
    return p == PtrW'(Depth - 1) ? '0 : p + 1'b1;
  endfunction
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= owner;
        wptr_q        <= nxt(wptr_q);
      end
      if (pop) rptr_q <= nxt(rptr_q);
      cnt_q <= cnt_q + CntW'(push) - CntW'(pop);
    end
  end
  assign head  = instr_owner_e'(mem_q[rptr_q]);
  assign empty = cnt_q == '0;
  assign full  = cnt_q == CntW'(Depth);
  assign count = cnt_q;
endmodule

// File: rtl/ibex_instr_bus_arbiter.sv
// ibex_instr_bus_arbiter: round-robin share of the instruction memory port between IF and an aux requester
module ibex_instr_bus_arbiter
  import ibex_instr_bus_arbiter_pkg::*;
#(
  parameter int MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  output logic        if_err_o,
  input  logic        aux_req_i,
  input  logic [31:0] aux_addr_i,
  output logic        aux_gnt_o,
  output logic        aux_rvalid_o,
  output logic [31:0] aux_rdata_o,
  output logic        aux_err_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i,
  output logic        busy_o
);
  localparam int CntW = $clog2(MaxOutstanding + 1);
  instr_owner_e    sel, sel_q, last_q, head;
  logic            lock_q, post_reset_q, sel_req, hs, pop, empty, full;
  logic [CntW-1:0] count_q;
  always_comb begin
    sel = lock_q ? sel_q :
          (if_req_i & aux_req_i) ? (last_q == INSTR_OWNER_IF ? INSTR_OWNER_AUX : INSTR_OWNER_IF) :
          aux_req_i ? INSTR_OWNER_AUX : INSTR_OWNER_IF;
  end
  // full is registered, so a same-cycle pop never opens a slot for this cycle's grant
  assign sel_req      = sel == INSTR_OWNER_AUX ? aux_req_i : if_req_i;
  assign mem_req_o    = sel_req & ~full;
  assign mem_addr_o   = sel == INSTR_OWNER_AUX ? aux_addr_i : if_addr_i;
  assign hs           = mem_req_o & mem_gnt_i;
  assign if_gnt_o     = hs & (sel == INSTR_OWNER_IF);
  assign aux_gnt_o    = hs & (sel == INSTR_OWNER_AUX);
  assign pop          = mem_rvalid_i & ~empty;
  assign if_rvalid_o  = pop & (head == INSTR_OWNER_IF);
  assign aux_rvalid_o = pop & (head == INSTR_OWNER_AUX);
  assign if_err_o     = if_rvalid_o & mem_err_i;
  assign aux_err_o    = aux_rvalid_o & mem_err_i;
  assign if_rdata_o   = mem_rdata_i;
  assign aux_rdata_o  = mem_rdata_i;
  assign busy_o       = count_q != '0;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q       <= 1'b0;
      sel_q        <= INSTR_OWNER_IF;
      last_q       <= INSTR_OWNER_AUX;
      post_reset_q <= 1'b1;
    end else if (hs) begin
      lock_q       <= 1'b0;
      last_q       <= sel;
      post_reset_q <= 1'b0;
    end else if (mem_req_o) begin
      lock_q <= 1'b1;
      sel_q  <= sel;
    end else if (lock_q & ~sel_req) begin
      lock_q <= 1'b0;
    end
  end
  ibex_instr_owner_fifo #(.Depth(MaxOutstanding)) u_owner_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (hs),
    .owner  (sel),
    .pop    (pop),
    .head   (head),
    .empty  (empty),
    .full   (full),
    .count  (count_q)
  );
  // late responses that straddle a reset are tolerated until the first new grant
  a_rvalid_owned: assert property (@(posedge clk_i) disable iff (!rst_ni)
    mem_rvalid_i |-> !empty || post_reset_q);
  a_addr_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    mem_req_o && !mem_gnt_i |=> !mem_req_o || mem_addr_o == $past(mem_addr_o));
  a_count_max: assert property (@(posedge clk_i) disable iff (!rst_ni)
    count_q <= CntW'(MaxOutstanding));
  a_gnt_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0({if_gnt_o, aux_gnt_o}));
  a_rvalid_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0({if_rvalid_o, aux_rvalid_o}));
endmodule

// File: tb/tb_ibex_instr_bus_arbiter.sv
// tb_ibex_instr_bus_arbiter: directed checks of arbitration, locking, outstanding limit and response routing
module tb_ibex_instr_bus_arbiter;
  logic        clk = 1'b0, rst_ni;
  logic        if_req, aux_req, mem_gnt, mem_rvalid, mem_err;
  logic [31:0] if_addr, aux_addr, mem_rdata;
  logic        if_gnt, if_rvalid, if_err, aux_gnt, aux_rvalid, aux_err, mem_req, busy;
  logic [31:0] if_rdata, aux_rdata, mem_addr;
  int n_cmp = 0, n_bad = 0;

  ibex_instr_bus_arbiter #(.MaxOutstanding(2)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
    .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata), .if_err_o(if_err),
    .aux_req_i(aux_req), .aux_addr_i(aux_addr), .aux_gnt_o(aux_gnt),
    .aux_rvalid_o(aux_rvalid), .aux_rdata_o(aux_rdata), .aux_err_o(aux_err),
    .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_gnt_i(mem_gnt),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata), .mem_err_i(mem_err),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // apply one cycle of stimulus just after the rising edge, then stop at the falling edge to sample
  task automatic drive(input logic ir, input logic [31:0] ia, input logic ar, input logic [31:0] aa,
                       input logic g, input logic rv, input logic [31:0] rd, input logic er);
    @(posedge clk);
    #1;
    if_req = ir; if_addr = ia; aux_req = ar; aux_addr = aa;
    mem_gnt = g; mem_rvalid = rv; mem_rdata = rd; mem_err = er;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_ni = 1'b0;
    if_req = 0; if_addr = 0; aux_req = 0; aux_addr = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0; mem_err = 0;
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
  endtask

  initial begin
    rst_ni = 1'b0;
    if_req = 0; if_addr = 0; aux_req = 0; aux_addr = 0;
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF; mem_err = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_gnt", {if_gnt, aux_gnt}, 0);
    chk("rst_rvalid", {if_rvalid, aux_rvalid}, 0);
    chk("rst_err", {if_err, aux_err}, 0);
    chk("rst_busy", busy, 0);
    do_reset();

    // IF-only stream
    drive(1, 32'h80, 0, 0, 1, 0, 0, 0);
    chk("t1_req", mem_req, 1); chk("t1_addr0", mem_addr, 32'h80);
    chk("t1_gnt0", {if_gnt, aux_gnt}, 2'b10);
    drive(1, 32'h84, 0, 0, 1, 1, 32'h1111_0000, 0);
    chk("t1_addr1", mem_addr, 32'h84); chk("t1_gnt1", {if_gnt, aux_gnt}, 2'b10);
    chk("t1_rv0", {if_rvalid, aux_rvalid}, 2'b10); chk("t1_rd0", if_rdata, 32'h1111_0000);
    drive(1, 32'h88, 0, 0, 1, 1, 32'h2222_0000, 0);
    chk("t1_addr2", mem_addr, 32'h88);
    chk("t1_rv1", {if_rvalid, aux_rvalid}, 2'b10); chk("t1_rd1", if_rdata, 32'h2222_0000);
    drive(0, 0, 0, 0, 0, 1, 32'h3333_0000, 0);
    chk("t1_rv2", {if_rvalid, aux_rvalid}, 2'b10); chk("t1_busy_hi", busy, 1);
    chk("t1_req_lo", mem_req, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t1_busy_lo", busy, 0); chk("t1_rv_idle", {if_rvalid, aux_rvalid}, 0);

    // both requesting: round-robin from reset, IF first
    do_reset();
    drive(1, 32'h100, 1, 32'h200, 1, 0, 0, 0);
    chk("t2_g0", {if_gnt, aux_gnt}, 2'b10); chk("t2_a0", mem_addr, 32'h100);
    drive(1, 32'h100, 1, 32'h200, 1, 1, 32'hA0, 0);
    chk("t2_g1", {if_gnt, aux_gnt}, 2'b01); chk("t2_a1", mem_addr, 32'h200);
    chk("t2_rv1", {if_rvalid, aux_rvalid}, 2'b10);
    drive(1, 32'h100, 1, 32'h200, 1, 1, 32'hA1, 0);
    chk("t2_g2", {if_gnt, aux_gnt}, 2'b10); chk("t2_a2", mem_addr, 32'h100);
    chk("t2_rv2", {if_rvalid, aux_rvalid}, 2'b01); chk("t2_rd2", aux_rdata, 32'hA1);
    drive(1, 32'h100, 1, 32'h200, 1, 1, 32'hA2, 0);
    chk("t2_g3", {if_gnt, aux_gnt}, 2'b01); chk("t2_a3", mem_addr, 32'h200);
    chk("t2_rv3", {if_rvalid, aux_rvalid}, 2'b10);
    drive(0, 0, 0, 0, 0, 1, 32'hA3, 0);
    chk("t2_rv4", {if_rvalid, aux_rvalid}, 2'b01);

    // AUX stalled by memory for 3 cycles, address held, IF waits
    drive(0, 0, 1, 32'h1A11_0800, 0, 0, 0, 0);
    chk("t3_req0", mem_req, 1); chk("t3_a0", mem_addr, 32'h1A11_0800);
    chk("t3_g0", {if_gnt, aux_gnt}, 0);
    drive(1, 32'h300, 1, 32'h1A11_0800, 0, 0, 0, 0);
    chk("t3_a1", mem_addr, 32'h1A11_0800); chk("t3_g1", {if_gnt, aux_gnt}, 0);
    drive(1, 32'h300, 1, 32'h1A11_0800, 0, 0, 0, 0);
    chk("t3_a2", mem_addr, 32'h1A11_0800);
    drive(1, 32'h300, 1, 32'h1A11_0800, 1, 0, 0, 0);
    chk("t3_a3", mem_addr, 32'h1A11_0800); chk("t3_g3", {if_gnt, aux_gnt}, 2'b01);
    drive(1, 32'h300, 1, 32'h1A11_0800, 1, 1, 32'hB0, 0);
    chk("t3_g4", {if_gnt, aux_gnt}, 2'b10); chk("t3_a4", mem_addr, 32'h300);
    chk("t3_rv4", {if_rvalid, aux_rvalid}, 2'b01);
    drive(0, 0, 0, 0, 0, 1, 32'hB1, 0);
    chk("t3_rv5", {if_rvalid, aux_rvalid}, 2'b10);

    // outstanding limit of 2, same-cycle pop does not free a slot
    drive(1, 32'h400, 0, 0, 1, 0, 0, 0);
    chk("t4_g0", if_gnt, 1);
    drive(1, 32'h404, 0, 0, 1, 0, 0, 0);
    chk("t4_g1", if_gnt, 1);
    drive(1, 32'h408, 0, 0, 1, 0, 0, 0);
    chk("t4_req_full", mem_req, 0); chk("t4_g_full", if_gnt, 0); chk("t4_busy", busy, 1);
    drive(1, 32'h408, 0, 0, 1, 1, 32'hC0, 0);
    chk("t4_req_pop", mem_req, 0); chk("t4_g_pop", if_gnt, 0);
    chk("t4_rv_pop", if_rvalid, 1);
    drive(1, 32'h408, 0, 0, 1, 1, 32'hC1, 0);
    chk("t4_req_resume", mem_req, 1); chk("t4_g_resume", if_gnt, 1);
    chk("t4_rv_resume", if_rvalid, 1);
    drive(0, 0, 0, 0, 0, 1, 32'hC2, 0);
    chk("t4_rv_last", if_rvalid, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t4_idle", busy, 0);

    // interleaved owners with an error on the AUX response
    drive(1, 32'h500, 0, 0, 1, 0, 0, 0);
    chk("t5_g0", {if_gnt, aux_gnt}, 2'b10);
    drive(0, 0, 1, 32'h600, 1, 0, 0, 0);
    chk("t5_g1", {if_gnt, aux_gnt}, 2'b01);
    drive(0, 0, 0, 0, 0, 1, 32'hD5, 0);
    chk("t5_rv0", {if_rvalid, aux_rvalid}, 2'b10); chk("t5_err0", {if_err, aux_err}, 0);
    drive(1, 32'h504, 0, 0, 1, 1, 32'hD6, 1);
    chk("t5_rv1", {if_rvalid, aux_rvalid}, 2'b01); chk("t5_err1", {if_err, aux_err}, 2'b01);
    chk("t5_rd1", aux_rdata, 32'hD6); chk("t5_g2", if_gnt, 1);
    drive(0, 0, 0, 0, 0, 1, 32'hD7, 0);
    chk("t5_rv2", {if_rvalid, aux_rvalid}, 2'b10); chk("t5_err2", {if_err, aux_err}, 0);
    chk("t5_rd2", if_rdata, 32'hD7);

    // reset with two outstanding, then a late response
    drive(1, 32'h700, 0, 0, 1, 0, 0, 0);
    chk("t6_g0", if_gnt, 1);
    drive(0, 0, 1, 32'h800, 1, 0, 0, 0);
    chk("t6_g1", aux_gnt, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t6_busy_pre", busy, 1);
    rst_ni = 1'b0;
    #1;
    chk("t6_busy_rst", busy, 0); chk("t6_req_rst", mem_req, 0);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    drive(0, 0, 0, 0, 0, 1, 32'hE0, 0);
    chk("t6_late_rv", {if_rvalid, aux_rvalid}, 0); chk("t6_late_err", {if_err, aux_err}, 0);
    chk("t6_busy_post", busy, 0);
    drive(1, 32'h900, 1, 32'hA00, 1, 0, 0, 0);
    chk("t6_tie_after_rst", {if_gnt, aux_gnt}, 2'b10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ibex_instr_bus_arbiter.md
# ibex_instr_bus_arbiter

Shares the single instruction-memory port between two requesters: the IF stage fetch unit (prefetch buffer or I-cache) and an auxiliary requester (debug-module program-buffer fetch or a loader/DMA). It sits between the IF stage's instruction interface and the external memory bus. It arbitrates requests round-robin and holds a pending request stable until granted. It records the owner of every granted transaction and routes in-order responses (rvalid/rdata/err) back to the owning requester.

## Interface
Parameters:
- MaxOutstanding, default 2: maximum granted-but-unanswered transactions on the memory port; must be ≥1.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- if_req_i / aux_req_i  in  1  request from the IF stage / auxiliary requester.
- if_addr_i / aux_addr_i  in  32  word-aligned request address.
- if_gnt_o / aux_gnt_o  out  1  grant; combinational from mem_gnt_i.
- if_rvalid_o / aux_rvalid_o  out  1  response valid for this requester.
- if_rdata_o / aux_rdata_o  out  32  response data, copied from mem_rdata_i.
- if_err_o / aux_err_o  out  1  bus error, valid with the matching rvalid.
- mem_req_o  out  1  request to memory.
- mem_addr_o  out  32  address of the selected requester.
- mem_gnt_i  in  1  memory grant.
- mem_rvalid_i  in  1  memory response valid; responses arrive in order.
- mem_rdata_i  in  32  response data.
- mem_err_i  in  1  response error.
- busy_o  out  1  high when the outstanding count is nonzero.

## Operation
- Selection (combinational):
  - If lock_q is set, the selected owner is sel_q.
  - Otherwise, if only one requester requests, that requester is selected.
  - If both request, the requester not equal to last_q is selected. last_q resets to AUX, so IF wins the first tie.
- mem_req_o = selected requester's req AND (count_q < MaxOutstanding). mem_addr_o = selected address.
  - When no requester is asserting, the address is a don't-care; implementation drives the IF address.
- gnt_o of the selected requester = mem_gnt_i AND mem_req_o. The other requester's gnt_o is 0.
- Handshake completes when mem_req_o AND mem_gnt_i:
  - push the owner into the owner FIFO;
  - last_q <= owner;
  - clear lock_q.
- mem_req_o AND NOT mem_gnt_i: lock_q <= 1 and sel_q <= owner. This holds selection so the requester's address stays stable, per bus rules.
- Outstanding limit: with count_q == MaxOutstanding, mem_req_o is forced to 0.
  - Selection and lock are still evaluated and retained, but no new lock is created while mem_req_o is 0.
  - A same-cycle pop does not free a slot for the same-cycle grant. This avoids an rvalid→req combinational path.
- Response: when mem_rvalid_i is high, the FIFO head owner receives rvalid, rdata and err combinationally, and the FIFO pops.
  - The non-owner's rvalid_o and err_o are 0; its rdata_o is don't-care (driven from mem_rdata_i).
- Simultaneous grant and rvalid: push and pop in the same cycle; count_q is unchanged.
- Protocol violations (assertion only):
  - rvalid with an empty FIFO: the response is dropped and no rvalid_o is raised;
  - the requester deasserts req while locked: lock clears.
- count_q width is $clog2(MaxOutstanding+1); it never exceeds MaxOutstanding.

## Timing
- Zero-cycle path from req/addr to mem_req/mem_addr, and from mem_gnt_i to gnt_o.
- Zero-cycle path from mem_rvalid_i to the routed rvalid/rdata/err.
- The owner becomes visible to the response router in the cycle after the grant. The earliest legal rvalid is one cycle after gnt.
- Reset values:
  - count_q = 0; lock_q = 0; sel_q = IF; last_q = AUX; FIFO empty;
  - all gnt_o/rvalid_o/err_o/mem_req_o = 0; busy_o = 0.
- Reset mid-transaction discards all owner records. Late memory responses after reset are dropped as in the empty-FIFO case.

## Structure
- ibex_pkg gains typedef enum logic {INSTR_OWNER_IF = 1'b0, INSTR_OWNER_AUX = 1'b1} instr_owner_e.
- Sub-module ibex_instr_owner_fifo (parameter Depth = MaxOutstanding, 1-bit entries):
  - ports: push, pop, head, empty, full, count;
  - circular pointers that wrap at Depth, with asynchronous active-low reset.
- Assertions: no rvalid with empty FIFO; locked address stable until gnt; count_q ≤ MaxOutstanding; at most one gnt_o and one rvalid_o high.

## Test plan
- IF-only stream, memory grants every cycle, rvalid 1 cycle later:
  - IF fetches 0x80, 0x84, 0x88 back-to-back;
  - responses route only to IF; aux_rvalid_o stays 0; busy_o returns to 0.
- Both requesting continuously, immediate gnt:
  - grants alternate IF, AUX, IF, AUX starting with IF after reset;
  - mem_addr_o alternates between the two addresses accordingly.
- AUX requests at 0x1A110800 and memory withholds gnt for 3 cycles while IF also requests:
  - mem_addr_o stays 0x1A110800 for all 4 cycles;
  - the grant goes to AUX; IF is granted next.
- MaxOutstanding=2, memory grants but delays rvalid:
  - after 2 grants mem_req_o drops to 0;
  - rvalid with a simultaneous request → no grant that cycle; grant resumes the next cycle.
- Interleaved owners IF, AUX, IF outstanding, with the middle response carrying mem_err_i = 1:
  - if_rvalid_o, then aux_rvalid_o with aux_err_o = 1, then if_rvalid_o;
  - if_err_o stays 0.
- Assert rst_ni with 2 outstanding, release, then pulse mem_rvalid_i:
  - no rvalid_o asserted;
  - count_q = 0 and all outputs at reset values.
